// File: rtl/tcp_rx_demux.sv
// TCP receive demux: parses the TCP source/destination ports of each IP frame and
// steers the whole frame to the lowest-indexed matching stream, or drops and counts it.
module tcp_rx_demux #(
    parameter int NUM_TCP    = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    s_ip_hdr_valid,
    output logic                    s_ip_hdr_ready,
    input  logic [7:0]              s_ip_protocol,
    input  logic [31:0]             s_ip_source_ip,
    input  logic [31:0]             s_ip_dest_ip,
    input  logic [15:0]             s_ip_length,
    input  logic [DATA_WIDTH-1:0]   s_ip_payload_tdata,
    input  logic                    s_ip_payload_tvalid,
    output logic                    s_ip_payload_tready,
    input  logic                    s_ip_payload_tlast,
    input  logic [NUM_TCP-1:0]      i_stream_en,
    input  logic [16*NUM_TCP-1:0]   i_local_port,
    input  logic [16*NUM_TCP-1:0]   i_remote_port,
    output logic [NUM_TCP-1:0]      m_ip_hdr_valid,
    input  logic [NUM_TCP-1:0]      m_ip_hdr_ready,
    output logic [7:0]              m_ip_protocol,
    output logic [31:0]             m_ip_source_ip,
    output logic [31:0]             m_ip_dest_ip,
    output logic [15:0]             m_ip_length,
    output logic [DATA_WIDTH-1:0]   m_ip_payload_tdata,
    output logic [NUM_TCP-1:0]      m_ip_payload_tvalid,
    input  logic [NUM_TCP-1:0]      m_ip_payload_tready,
    output logic                    m_ip_payload_tlast,
    output logic [15:0]             o_drop_count
);

    localparam int unsigned SEL_W = (NUM_TCP > 1) ? $clog2(NUM_TCP) : 1;

    typedef enum logic [2:0] {IDLE, PARSE, HDR_OUT, REPLAY, PASS, DROP} state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  byte_buf [4];
    logic [1:0]             idx;
    logic [1:0]             rep_idx;
    logic                   last3;
    logic [SEL_W-1:0]       sel;
    logic [NUM_TCP-1:0]     sel_oh;
    logic [15:0]            src_port;
    logic [15:0]            dst_port;
    logic                   match_any;
    logic [SEL_W-1:0]       match_sel;
    logic                   s_beat;

    assign sel_oh   = NUM_TCP'(1) << sel;
    assign s_beat   = s_ip_payload_tvalid && s_ip_payload_tready;
    // Destination port's low byte is the byte being accepted right now.
    assign src_port = 16'({byte_buf[0], byte_buf[1]});
    assign dst_port = 16'({byte_buf[2], s_ip_payload_tdata});

    // Lowest-index enabled stream whose local/remote ports match (remote 0 = any).
    always_comb begin
        match_any = 1'b0;
        match_sel = '0;
        for (int i = NUM_TCP - 1; i >= 0; i--) begin
            if (i_stream_en[i] && (i_local_port[16*i +: 16] == dst_port) &&
                ((i_remote_port[16*i +: 16] == 16'd0) || (i_remote_port[16*i +: 16] == src_port))) begin
                match_any = 1'b1;
                match_sel = SEL_W'(i);
            end
        end
    end

    // Payload/header steering; PASS is a zero-latency combinational path.
    always_comb begin
        s_ip_payload_tready = 1'b0;
        m_ip_hdr_valid      = '0;
        m_ip_payload_tvalid = '0;
        m_ip_payload_tdata  = byte_buf[rep_idx];
        m_ip_payload_tlast  = 1'b0;
        unique case (state)
            PARSE, DROP: s_ip_payload_tready = 1'b1;
            HDR_OUT:     m_ip_hdr_valid = sel_oh;
            REPLAY: begin
                m_ip_payload_tvalid = sel_oh;
                m_ip_payload_tlast  = (rep_idx == 2'd3) && last3;
            end
            PASS: begin
                s_ip_payload_tready = m_ip_payload_tready[sel];
                m_ip_payload_tvalid = s_ip_payload_tvalid ? sel_oh : '0;
                m_ip_payload_tdata  = s_ip_payload_tdata;
                m_ip_payload_tlast  = s_ip_payload_tlast;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            s_ip_hdr_ready <= 1'b0;
            m_ip_protocol  <= '0;
            m_ip_source_ip <= '0;
            m_ip_dest_ip   <= '0;
            m_ip_length    <= '0;
            for (int i = 0; i < 4; i++) byte_buf[i] <= '0;
            idx            <= '0;
            rep_idx        <= '0;
            last3          <= 1'b0;
            sel            <= '0;
            o_drop_count   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s_ip_hdr_valid && s_ip_hdr_ready) begin
                        m_ip_protocol  <= s_ip_protocol;
                        m_ip_source_ip <= s_ip_source_ip;
                        m_ip_dest_ip   <= s_ip_dest_ip;
                        m_ip_length    <= s_ip_length;
                        idx            <= '0;
                        s_ip_hdr_ready <= 1'b0;
                        state          <= (s_ip_protocol == 8'h06) ? PARSE : DROP;
                    end else begin
                        s_ip_hdr_ready <= 1'b1;
                    end
                end
                PARSE: begin
                    if (s_beat) begin
                        byte_buf[idx] <= s_ip_payload_tdata;
                        if (idx == 2'd3) begin
                            if (match_any) begin
                                sel     <= match_sel;
                                last3   <= s_ip_payload_tlast;
                                rep_idx <= '0;
                                state   <= HDR_OUT;
                            end else if (s_ip_payload_tlast) begin
                                if (o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 16'd1;
                                s_ip_hdr_ready <= 1'b1;
                                state          <= IDLE;
                            end else begin
                                state <= DROP;
                            end
                        end else if (s_ip_payload_tlast) begin
                            if (o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 16'd1;
                            s_ip_hdr_ready <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                HDR_OUT: begin
                    if (m_ip_hdr_ready[sel]) state <= REPLAY;
                end
                REPLAY: begin
                    if (m_ip_payload_tready[sel]) begin
                        rep_idx <= rep_idx + 2'd1;
                        if (rep_idx == 2'd3) begin
                            if (last3) begin
                                s_ip_hdr_ready <= 1'b1;
                                state          <= IDLE;
                            end else begin
                                state <= PASS;
                            end
                        end
                    end
                end
                PASS: begin
                    if (s_beat && s_ip_payload_tlast) begin
                        s_ip_hdr_ready <= 1'b1;
                        state          <= IDLE;
                    end
                end
                DROP: begin
                    if (s_beat && s_ip_payload_tlast) begin
                        if (o_drop_count != 16'hFFFF) o_drop_count <= o_drop_count + 16'd1;
                        s_ip_hdr_ready <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_rx_demux.sv
// Randomized self-checking bench for tcp_rx_demux against a frame-level routing model.
module tb_tcp_rx_demux;

    localparam int NUM_TCP = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   s_ip_hdr_valid;
    logic                   s_ip_hdr_ready;
    logic [7:0]             s_ip_protocol;
    logic [31:0]            s_ip_source_ip;
    logic [31:0]            s_ip_dest_ip;
    logic [15:0]            s_ip_length;
    logic [7:0]             s_ip_payload_tdata;
    logic                   s_ip_payload_tvalid;
    logic                   s_ip_payload_tready;
    logic                   s_ip_payload_tlast;
    logic [NUM_TCP-1:0]     i_stream_en;
    logic [16*NUM_TCP-1:0]  i_local_port;
    logic [16*NUM_TCP-1:0]  i_remote_port;
    logic [NUM_TCP-1:0]     m_ip_hdr_valid;
    logic [NUM_TCP-1:0]     m_ip_hdr_ready;
    logic [7:0]             m_ip_protocol;
    logic [31:0]            m_ip_source_ip;
    logic [31:0]            m_ip_dest_ip;
    logic [15:0]            m_ip_length;
    logic [7:0]             m_ip_payload_tdata;
    logic [NUM_TCP-1:0]     m_ip_payload_tvalid;
    logic [NUM_TCP-1:0]     m_ip_payload_tready;
    logic                   m_ip_payload_tlast;
    logic [15:0]            o_drop_count;

    logic [15:0] lport [NUM_TCP];
    logic [15:0] rport [NUM_TCP];

    always_comb begin
        for (int i = 0; i < NUM_TCP; i++) begin
            i_local_port[16*i +: 16]  = lport[i];
            i_remote_port[16*i +: 16] = rport[i];
        end
    end

    always #5 clk = ~clk;

    tcp_rx_demux #(.NUM_TCP(NUM_TCP), .DATA_WIDTH(8)) dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .s_ip_hdr_valid      (s_ip_hdr_valid),
        .s_ip_hdr_ready      (s_ip_hdr_ready),
        .s_ip_protocol       (s_ip_protocol),
        .s_ip_source_ip      (s_ip_source_ip),
        .s_ip_dest_ip        (s_ip_dest_ip),
        .s_ip_length         (s_ip_length),
        .s_ip_payload_tdata  (s_ip_payload_tdata),
        .s_ip_payload_tvalid (s_ip_payload_tvalid),
        .s_ip_payload_tready (s_ip_payload_tready),
        .s_ip_payload_tlast  (s_ip_payload_tlast),
        .i_stream_en         (i_stream_en),
        .i_local_port        (i_local_port),
        .i_remote_port       (i_remote_port),
        .m_ip_hdr_valid      (m_ip_hdr_valid),
        .m_ip_hdr_ready      (m_ip_hdr_ready),
        .m_ip_protocol       (m_ip_protocol),
        .m_ip_source_ip      (m_ip_source_ip),
        .m_ip_dest_ip        (m_ip_dest_ip),
        .m_ip_length         (m_ip_length),
        .m_ip_payload_tdata  (m_ip_payload_tdata),
        .m_ip_payload_tvalid (m_ip_payload_tvalid),
        .m_ip_payload_tready (m_ip_payload_tready),
        .m_ip_payload_tlast  (m_ip_payload_tlast),
        .o_drop_count        (o_drop_count)
    );

    int checks   = 0;
    int failures = 0;
    int exp_drops = 0;

    // Current frame and what came out of the DUT for it
    logic [7:0]  tx_q [$];
    logic [7:0]  rx_q [$];
    logic [7:0]  cur_proto;
    logic [31:0] cur_sip, cur_dip;
    logic [15:0] cur_len;
    int          route, perr, rx_last_pos, rx_tlast_cnt;
    bit          tmo;

    task automatic cfg_clear();
        i_stream_en = '0;
        for (int i = 0; i < NUM_TCP; i++) begin
            lport[i] = 16'd0;
            rport[i] = 16'd0;
        end
    endtask

    task automatic build_frame(input logic [7:0] proto, input logic [15:0] src,
                               input logic [15:0] dst, input int len);
        logic [7:0] hb [4];
        hb[0] = src[15:8]; hb[1] = src[7:0]; hb[2] = dst[15:8]; hb[3] = dst[7:0];
        tx_q.delete();
        for (int i = 0; i < len; i++)
            tx_q.push_back((i < 4) ? hb[i] : 8'($urandom));
        cur_proto = proto;
        cur_sip   = $urandom;
        cur_dip   = $urandom;
        cur_len   = 16'(len + 40);
    endtask

    // Reference routing: first enabled stream with local == dst and remote in {0, src}.
    function automatic int model_route();
        logic [15:0] src, dst;
        if (cur_proto != 8'h06 || tx_q.size() < 4) return -1;
        src = {tx_q[0], tx_q[1]};
        dst = {tx_q[2], tx_q[3]};
        for (int i = 0; i < NUM_TCP; i++)
            if (i_stream_en[i] && lport[i] == dst && (rport[i] == 16'd0 || rport[i] == src))
                return i;
        return -1;
    endfunction

    function automatic int oh_idx(input logic [NUM_TCP-1:0] v);
        for (int i = 0; i < NUM_TCP; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Differences between delivered and sent bytes (tlast must be on the final byte only)
    function automatic int data_errs();
        int e = 0;
        if (rx_q.size() != tx_q.size()) e++;
        for (int i = 0; i < rx_q.size() && i < tx_q.size(); i++)
            if (rx_q[i] !== tx_q[i]) e++;
        if (rx_tlast_cnt != 1 || rx_last_pos != tx_q.size() - 1) e++;
        return e;
    endfunction

    // Drive one frame with random valid/ready gaps and record everything the DUT emits.
    task automatic run_frame(input int rdy_pct, input int vld_pct);
        int p = 0;
        int cyc = 0;
        int k;
        bit hdr_sent = 0;
        bit hdr_now, beat;
        rx_q.delete();
        route = -1; perr = 0; rx_last_pos = -1; rx_tlast_cnt = 0; tmo = 0;
        @(posedge clk); #1;
        s_ip_hdr_valid = 1'b1;
        s_ip_protocol  = cur_proto;
        s_ip_source_ip = cur_sip;
        s_ip_dest_ip   = cur_dip;
        s_ip_length    = cur_len;
        forever begin
            if (hdr_sent) begin
                if (p < tx_q.size()) begin
                    if (!s_ip_payload_tvalid) s_ip_payload_tvalid = ($urandom_range(99) < vld_pct);
                    s_ip_payload_tdata = tx_q[p];
                    s_ip_payload_tlast = (p == tx_q.size() - 1);
                end else begin
                    s_ip_payload_tvalid = 1'b0;
                    s_ip_payload_tlast  = 1'b0;
                end
            end
            for (int i = 0; i < NUM_TCP; i++) begin
                m_ip_hdr_ready[i]      = ($urandom_range(99) < rdy_pct);
                m_ip_payload_tready[i] = ($urandom_range(99) < rdy_pct);
            end
            @(negedge clk);
            if (hdr_sent && p == tx_q.size() && s_ip_hdr_ready) break;
            hdr_now = !hdr_sent && s_ip_hdr_valid && s_ip_hdr_ready;
            beat    = s_ip_payload_tvalid && s_ip_payload_tready;
            if (m_ip_hdr_valid != '0) begin
                if (!$onehot(m_ip_hdr_valid)) perr++;
                k = oh_idx(m_ip_hdr_valid);
                if (route == -1) route = k; else if (route != k) perr++;
                if (m_ip_protocol !== cur_proto || m_ip_source_ip !== cur_sip ||
                    m_ip_dest_ip !== cur_dip || m_ip_length !== cur_len) perr++;
            end
            if (m_ip_payload_tvalid != '0) begin
                if (!$onehot(m_ip_payload_tvalid)) perr++;
                k = oh_idx(m_ip_payload_tvalid);
                if (k != route) perr++;
                // Past the 4 replayed bytes the output must mirror the input handshake.
                if (rx_q.size() >= 4 && (!s_ip_payload_tvalid ||
                    s_ip_payload_tready !== m_ip_payload_tready[k] ||
                    m_ip_payload_tdata !== s_ip_payload_tdata ||
                    m_ip_payload_tlast !== s_ip_payload_tlast)) perr++;
                if (m_ip_payload_tready[k]) begin
                    rx_q.push_back(m_ip_payload_tdata);
                    if (m_ip_payload_tlast) begin
                        rx_tlast_cnt++;
                        rx_last_pos = rx_q.size() - 1;
                    end
                end
            end
            @(posedge clk); #1;
            if (hdr_now) begin
                hdr_sent = 1;
                s_ip_hdr_valid = 1'b0;
            end
            if (beat) begin
                p++;
                s_ip_payload_tvalid = 1'b0;
            end
            cyc++;
            if (cyc > 3000) begin
                tmo = 1;
                break;
            end
        end
        s_ip_hdr_valid      = 1'b0;
        s_ip_payload_tvalid = 1'b0;
        s_ip_payload_tlast  = 1'b0;
        m_ip_hdr_ready      = '0;
        m_ip_payload_tready = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_ip_hdr_ready !== 1'b0) begin failures++; $display("FAIL reset_hdr_ready got=%b exp=0", s_ip_hdr_ready); end
        checks++;
        if (s_ip_payload_tready !== 1'b0) begin failures++; $display("FAIL reset_tready got=%b exp=0", s_ip_payload_tready); end
        checks++;
        if (m_ip_hdr_valid !== '0 || m_ip_payload_tvalid !== '0) begin
            failures++; $display("FAIL reset_valids got=%h/%h exp=0/0", m_ip_hdr_valid, m_ip_payload_tvalid);
        end
        checks++;
        if (m_ip_payload_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast got=%b exp=0", m_ip_payload_tlast); end
        checks++;
        if (o_drop_count !== 16'd0) begin failures++; $display("FAIL reset_drop got=%0d exp=0", o_drop_count); end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_ip_hdr_ready !== 1'b1) begin failures++; $display("FAIL idle_hdr_ready got=%b exp=1", s_ip_hdr_ready); end
    endtask

    task automatic test_basic();
        cfg_clear();
        i_stream_en[2] = 1'b1; lport[2] = 16'h1F90; rport[2] = 16'h0000;
        build_frame(8'h06, 16'hC000, 16'h1F90, 20);
        run_frame(100, 100);
        checks++;
        if (route !== 2) begin failures++; $display("FAIL basic_route got=%0d exp=2", route); end
        checks++;
        if (data_errs() != 0) begin failures++; $display("FAIL basic_data errs=%0d rx=%0d exp=20 last=%0d", data_errs(), rx_q.size(), rx_last_pos); end
        checks++;
        if (perr != 0 || tmo) begin failures++; $display("FAIL basic_proto perr=%0d tmo=%0b exp=0/0", perr, tmo); end
        checks++;
        if (o_drop_count !== 16'(exp_drops)) begin failures++; $display("FAIL basic_drop got=%0d exp=%0d", o_drop_count, exp_drops); end
    endtask

    task automatic test_priority();
        cfg_clear();
        i_stream_en[1] = 1'b1; lport[1] = 16'h0050;
        i_stream_en[5] = 1'b1; lport[5] = 16'h0050;
        build_frame(8'h06, 16'hABCD, 16'h0050, 12);
        run_frame(100, 100);
        checks++;
        if (route !== 1) begin failures++; $display("FAIL prio_route got=%0d exp=1", route); end
        checks++;
        if (data_errs() != 0 || perr != 0 || tmo) begin
            failures++; $display("FAIL prio_data errs=%0d perr=%0d tmo=%0b exp=0", data_errs(), perr, tmo);
        end
    endtask

    task automatic test_drops();
        logic [7:0]  protos [3] = '{8'h11, 8'h06, 8'h06};
        logic [15:0] srcs   [3] = '{16'hC000, 16'hC000, 16'h2222};
        logic [15:0] dsts   [3] = '{16'h1F90, 16'h1234, 16'h1F90};
        for (int t = 0; t < 3; t++) begin
            cfg_clear();
            i_stream_en[2] = 1'b1; lport[2] = 16'h1F90;
            if (t == 2) begin
                i_stream_en = '0;
                i_stream_en[0] = 1'b1; lport[0] = 16'h1F90; rport[0] = 16'h1111;
            end
            build_frame(protos[t], srcs[t], dsts[t], 10);
            run_frame(100, 80);
            exp_drops++;
            checks++;
            if (route !== -1 || rx_q.size() != 0) begin
                failures++; $display("FAIL drop%0d_route got=%0d rx=%0d exp=-1/0", t, route, rx_q.size());
            end
            checks++;
            if (o_drop_count !== 16'(exp_drops) || tmo) begin
                failures++; $display("FAIL drop%0d_count got=%0d exp=%0d tmo=%0b", t, o_drop_count, exp_drops, tmo);
            end
        end
    endtask

    task automatic test_runt();
        cfg_clear();
        i_stream_en[3] = 1'b1; lport[3] = 16'h0016;
        build_frame(8'h06, 16'h4000, 16'h0016, 3);
        run_frame(100, 100);
        exp_drops++;
        checks++;
        if (route !== -1 || o_drop_count !== 16'(exp_drops) || tmo) begin
            failures++; $display("FAIL runt route=%0d drop=%0d exp=-1/%0d", route, o_drop_count, exp_drops);
        end
        build_frame(8'h06, 16'h4000, 16'h0016, 4);
        run_frame(60, 100);
        checks++;
        if (route !== 3) begin failures++; $display("FAIL hdr_only_route got=%0d exp=3", route); end
        checks++;
        if (data_errs() != 0 || perr != 0 || tmo) begin
            failures++; $display("FAIL hdr_only_data errs=%0d last=%0d exp=3 perr=%0d", data_errs(), rx_last_pos, perr);
        end
        checks++;
        if (o_drop_count !== 16'(exp_drops)) begin failures++; $display("FAIL hdr_only_drop got=%0d exp=%0d", o_drop_count, exp_drops); end
    endtask

    task automatic test_backpressure();
        logic [15:0] ports [4] = '{16'h0050, 16'h1F90, 16'h0016, 16'h01BB};
        logic [15:0] srcs  [2] = '{16'hC000, 16'hC001};
        int er;
        for (int f = 0; f < 24; f++) begin
            cfg_clear();
            i_stream_en = NUM_TCP'($urandom);
            for (int i = 0; i < NUM_TCP; i++) begin
                lport[i] = ports[$urandom_range(3)];
                rport[i] = ($urandom_range(1) == 0) ? 16'h0000 : srcs[$urandom_range(1)];
            end
            build_frame(($urandom_range(9) < 8) ? 8'h06 : 8'h11, srcs[$urandom_range(1)],
                        ports[$urandom_range(3)], $urandom_range(30, 1));
            er = model_route();
            run_frame(50, 70);
            if (er < 0) exp_drops++;
            checks++;
            if (route !== er) begin failures++; $display("FAIL bp%0d_route got=%0d exp=%0d", f, route, er); end
            checks++;
            if (er >= 0 ? (data_errs() != 0) : (rx_q.size() != 0)) begin
                failures++; $display("FAIL bp%0d_data rx=%0d exp=%0d last=%0d", f, rx_q.size(), (er >= 0) ? tx_q.size() : 0, rx_last_pos);
            end
            checks++;
            if (perr != 0 || tmo) begin failures++; $display("FAIL bp%0d_proto perr=%0d tmo=%0b exp=0/0", f, perr, tmo); end
            checks++;
            if (o_drop_count !== 16'(exp_drops)) begin failures++; $display("FAIL bp%0d_drop got=%0d exp=%0d", f, o_drop_count, exp_drops); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int p = 0;
        int cyc = 0;
        bit hdr_sent = 0;
        cfg_clear();
        i_stream_en[2] = 1'b1; lport[2] = 16'h1F90;
        build_frame(8'h06, 16'hC000, 16'h1F90, 20);
        m_ip_hdr_ready = '1;
        m_ip_payload_tready = '1;
        @(posedge clk); #1;
        s_ip_hdr_valid = 1'b1;
        s_ip_protocol = cur_proto; s_ip_source_ip = cur_sip; s_ip_dest_ip = cur_dip; s_ip_length = cur_len;
        while (p < 10 && cyc < 200) begin
            if (hdr_sent) begin
                s_ip_payload_tvalid = 1'b1;
                s_ip_payload_tdata  = tx_q[p];
                s_ip_payload_tlast  = 1'b0;
            end
            @(negedge clk);
            if (!hdr_sent && s_ip_hdr_ready) begin
                @(posedge clk); #1;
                hdr_sent = 1;
                s_ip_hdr_valid = 1'b0;
            end else begin
                if (s_ip_payload_tvalid && s_ip_payload_tready) p++;
                @(posedge clk); #1;
            end
            cyc++;
        end
        checks++;
        if (p < 10) begin failures++; $display("FAIL rst_mid_progress got=%0d exp=10", p); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (m_ip_payload_tvalid !== '0 || m_ip_hdr_valid !== '0 || s_ip_payload_tready !== 1'b0) begin
            failures++; $display("FAIL rst_mid_valids got=%h/%h/%b exp=0/0/0", m_ip_payload_tvalid, m_ip_hdr_valid, s_ip_payload_tready);
        end
        s_ip_payload_tvalid = 1'b0;
        m_ip_hdr_ready = '0;
        m_ip_payload_tready = '0;
        exp_drops = 0;
        @(negedge clk);
        rst_n = 1'b1;
        build_frame(8'h06, 16'hC000, 16'h1F90, 9);
        run_frame(70, 90);
        checks++;
        if (route !== 2 || data_errs() != 0 || perr != 0 || tmo) begin
            failures++; $display("FAIL rst_after_frame route=%0d exp=2 errs=%0d perr=%0d tmo=%0b", route, data_errs(), perr, tmo);
        end
        checks++;
        if (o_drop_count !== 16'd0) begin failures++; $display("FAIL rst_after_drop got=%0d exp=0", o_drop_count); end
    endtask

    initial begin
        s_ip_hdr_valid = 1'b0; s_ip_protocol = '0; s_ip_source_ip = '0; s_ip_dest_ip = '0; s_ip_length = '0;
        s_ip_payload_tdata = '0; s_ip_payload_tvalid = 1'b0; s_ip_payload_tlast = 1'b0;
        m_ip_hdr_ready = '0; m_ip_payload_tready = '0;
        cfg_clear();
        test_reset();
        test_basic();
        test_priority();
        test_drops();
        test_runt();
        test_backpressure();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tcp_rx_demux.md
Name: tcp_rx_demux

Overview:
- Receive-side counterpart of the per-stream TX arbitration mux in the TCP block.
- Accepts IP frames from the IP layer and parses the first 4 TCP header bytes (source and destination port).
- Steers each whole frame (IP header plus full payload) to exactly one of NUM_TCP tcp_stream RX ports, selected by enabled local/remote port match.
- Drops non-TCP, unmatched and runt frames, and counts drops.

Parameters:
- NUM_TCP, 8: number of tcp_stream outputs.
- DATA_WIDTH, 8: payload width in bits. Only 8 is supported.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- s_ip_hdr_valid / s_ip_hdr_ready  in/out  1/1  IP header handshake.
- s_ip_protocol  in  8  IP protocol field.
- s_ip_source_ip / s_ip_dest_ip  in  32/32  IP addresses.
- s_ip_length  in  16  IP total length.
- s_ip_payload_tdata  in  8  payload byte.
- s_ip_payload_tvalid / tready / tlast  in/out/in  1/1/1  payload stream handshake and end-of-frame.
- i_stream_en  in  NUM_TCP  per-stream enable (from regfile).
- i_local_port  in  16*NUM_TCP  per-stream local port, matched against the TCP destination port.
- i_remote_port  in  16*NUM_TCP  per-stream remote port, matched against the TCP source port. Value 0 is a wildcard.
- m_ip_hdr_valid  out  NUM_TCP  per-stream header valid, one-hot or zero.
- m_ip_hdr_ready  in  NUM_TCP  per-stream header ready.
- m_ip_protocol / m_ip_source_ip / m_ip_dest_ip / m_ip_length  out  8/32/32/16  broadcast header fields.
- m_ip_payload_tdata  out  8  broadcast payload byte.
- m_ip_payload_tvalid  out  NUM_TCP  per-stream payload valid, one-hot or zero.
- m_ip_payload_tready  in  NUM_TCP  per-stream payload ready.
- m_ip_payload_tlast  out  1  broadcast end-of-frame.
- o_drop_count  out  16  count of dropped frames, saturating.

Behaviour:
- Reset:
  - state = IDLE.
  - All s_*_ready, m_*_valid, m_ip_payload_tlast = 0.
  - Header registers, byte buffer and o_drop_count = 0.
- FSM states: IDLE, PARSE, HDR_OUT, REPLAY, PASS, DROP.
- IDLE:
  - s_ip_hdr_ready = 1.
  - On hdr handshake, latch all header fields and byte index idx = 0.
  - Go to PARSE if protocol == 8'h06, else DROP.
- PARSE:
  - s_ip_payload_tready = 1. Each accepted byte is stored in buf[idx] and idx increments.
  - If tlast arrives with idx < 3, the frame is a runt: increment the count, return to IDLE.
  - On the 4th byte (idx == 3) with tlast = 0:
    - src_port = {buf0, buf1}; dst_port = {buf2, buf3}.
    - Match i requires i_stream_en[i] && i_local_port[i] == dst_port && (i_remote_port[i] == 0 || i_remote_port[i] == src_port).
    - Select the lowest matching index, register sel, go to HDR_OUT.
    - With no match, go to DROP.
  - A 4th byte carrying tlast is a valid header-only TCP fragment: apply the same match. The tlast flag is kept for the replay of byte 3.
- HDR_OUT:
  - m_ip_hdr_valid[sel] = 1 from the cycle after the 4th byte is accepted.
  - Held until m_ip_hdr_ready[sel]; header fields are stable while valid.
  - Then go to REPLAY.
- REPLAY:
  - Emits buf0..buf3 on m_ip_payload_tdata with m_ip_payload_tvalid[sel], one byte per ready cycle.
  - tlast is asserted on buf3 only if the 4th input byte had tlast. In that case return to IDLE, else go to PASS.
  - s_ip_payload_tready = 0 during REPLAY.
- PASS:
  - Combinational pass-through, zero latency: m_tdata = s_tdata, m_tvalid[sel] = s_tvalid, s_tready = m_tready[sel], m_tlast = s_tlast.
  - On the tlast handshake, return to IDLE.
- DROP:
  - s_ip_payload_tready = 1. Consume until a tlast handshake, then increment o_drop_count (saturating at 16'hFFFF) and go to IDLE.
  - A frame with no payload cannot occur and is not handled.
- Valid signals never deassert without a handshake. Valid never depends on ready.
- Configuration inputs are sampled only at the 4th-byte match cycle. Changes mid-frame do not redirect the frame.
- Frame order is preserved. Only one frame is in flight; the next header is not accepted before return to IDLE.
- Asynchronous reset mid-frame returns to IDLE and discards the partial frame without counting it.

Test Plan:
- Stream 2: en = 1, local 0x1F90, remote 0. Send proto 6, src port 0xC000, dst 0x1F90, 20-byte payload -> stream 2 gets hdr_valid, then the 20 bytes unchanged with tlast on byte 20. Other streams idle. drop_count = 0.
- Streams 1 and 5 both match dst 0x0050 -> frame goes to stream 1 only.
- Proto 0x11 frame of 10 bytes -> all consumed, no m valid, drop_count = 1. Same for a TCP frame with dst 0x1234 and no match -> drop_count = 2.
- Runt: TCP frame of 3 bytes with tlast -> dropped, drop_count increments. A 4-byte frame to a matching port -> 4 bytes replayed with tlast on byte 4.
- Backpressure: m_ip_payload_tready[sel] toggled randomly (50%) during REPLAY and PASS -> byte sequence intact, no duplication or loss, s_tready mirrors the selected ready in PASS.
- Remote filter: stream 0 remote = 0x1111 and frame src = 0x2222 -> dropped. Assert i_rst_n = 0 mid-PASS -> all valids 0 immediately, FSM in IDLE, next frame routed correctly.
